// File: rtl/operand_fetch_if.sv
// Issue, write-back and ALU-side handshake bundle for operand_fetch.
// slave is the fetch stage; master is the issuing/consuming side.
interface operand_fetch_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned OPW  = 4;

    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rs;
    logic [AW-1:0]   in_rt;
    logic [OPW-1:0]  in_op;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;

    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    logic            out_valid;
    logic            out_ready;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] din1_alu;
    logic [XLEN-1:0] din2_alu;

    modport slave (
        input  in_valid, in_rs, in_rt, in_op, in_imm, in_use_imm,
        input  wb_en, wb_addr, wb_data,
        input  out_ready,
        output in_ready, out_valid, op, din1_alu, din2_alu
    );

    modport master (
        output in_valid, in_rs, in_rt, in_op, in_imm, in_use_imm,
        output wb_en, wb_addr, wb_data,
        output out_ready,
        input  in_ready, out_valid, op, din1_alu, din2_alu
    );
endinterface

// File: rtl/operand_fetch.sv
// Register file plus one-entry operand stage feeding the ALU.
// Define OPERAND_FETCH_WB_BYPASS_EN to forward same-cycle write-back data into the read.
module operand_fetch (
    input  logic            clk,
    input  logic            reset,
    operand_fetch_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned OPW  = 4;
    localparam int unsigned NREG = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [XLEN-1:0] din1_q, din1_d;
    logic [XLEN-1:0] din2_q, din2_d;
    logic [XLEN-1:0] rf_q [NREG];

    logic            in_ready_c;
    logic            accept_c;
    logic            wb_we_c;
    logic [XLEN-1:0] rs_val_c;
    logic [XLEN-1:0] rt_val_c;

    assign in_ready_c = (state_q == ST_EMPTY) || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign wb_we_c    = bus.wb_en && (bus.wb_addr != AW'(0));

    // Source reads; entry 0 is hard-wired to zero.
    always_comb begin
        rs_val_c = (bus.in_rs == AW'(0)) ? XLEN'(0) : rf_q[bus.in_rs];
        rt_val_c = (bus.in_rt == AW'(0)) ? XLEN'(0) : rf_q[bus.in_rt];
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        if (wb_we_c && (bus.wb_addr == bus.in_rs)) rs_val_c = bus.wb_data;
        if (wb_we_c && (bus.wb_addr == bus.in_rt)) rt_val_c = bus.wb_data;
`endif
    end

    // Next state and operand capture; held operands only change on acceptance.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        din1_d  = din1_q;
        din2_d  = din2_q;

        case (state_q)
            ST_EMPTY: if (accept_c) state_d = ST_FULL;
            ST_FULL:  if (bus.out_ready && !bus.in_valid) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (accept_c) begin
            op_d   = bus.in_op;
            din1_d = rs_val_c;
            din2_d = bus.in_use_imm ? bus.in_imm : rt_val_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            op_q    <= OPW'(0);
            din1_q  <= XLEN'(0);
            din2_q  <= XLEN'(0);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            din1_q  <= din1_d;
            din2_q  <= din2_d;
        end
    end

    // Write-back runs independently of the issue handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= XLEN'(0);
        end else if (wb_we_c) begin
            rf_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.op        = op_q;
    assign bus.din1_alu  = din1_q;
    assign bus.din2_alu  = din2_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a reference register file predicts each issue.
module tb_operand_fetch;
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    logic clk;
    logic reset;
    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t        sb[$];
    bit          m_valid = 1'b0;
    logic [31:0] mrf [32];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        if (bus.wb_en && (bus.wb_addr == a)) return bus.wb_data;
`endif
        return mrf[a];
    endfunction

    // Reference model: predicts acceptance and pushes expected operands.
    always @(posedge clk) begin
        bit   acc;
        exp_t e;
        if (reset) begin
            sb.delete();
            m_valid <= 1'b0;
            for (int i = 0; i < 32; i++) mrf[i] <= 32'd0;
        end else begin
            acc = bus.in_valid && (!m_valid || bus.out_ready);
            if (acc) begin
                e.op = bus.in_op;
                e.d1 = model_rd(bus.in_rs);
                e.d2 = bus.in_use_imm ? bus.in_imm : model_rd(bus.in_rt);
                sb.push_back(e);
                m_valid <= 1'b1;
            end else if (bus.out_ready) begin
                m_valid <= 1'b0;
            end
            if (bus.wb_en && (bus.wb_addr != 5'd0)) mrf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Mid-cycle monitor: handshake flags every cycle, operands against scoreboard front.
    always @(negedge clk) begin
        exp_t e;
        chk_eq("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
        chk_eq("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            chk_eq("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb[0];
                chk_eq("sb_op", 32'(bus.op), 32'(e.op));
                chk_eq("sb_din1", bus.din1_alu, e.d1);
                chk_eq("sb_din2", bus.din2_alu, e.d2);
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] opc,
                         input logic use_imm, input logic [31:0] imm);
        bus.in_valid   = 1'b1;
        bus.in_rs      = rs;
        bus.in_rt      = rt;
        bus.in_op      = opc;
        bus.in_use_imm = use_imm;
        bus.in_imm     = imm;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        tick();
        bus.wb_en   = 1'b0;
    endtask

    initial begin
        logic [31:0] bypass_exp;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_rs      = 5'd0;
        bus.in_rt      = 5'd0;
        bus.in_op      = 4'd0;
        bus.in_imm     = 32'd0;
        bus.in_use_imm = 1'b0;
        bus.wb_en      = 1'b0;
        bus.wb_addr    = 5'd0;
        bus.wb_data    = 32'd0;
        bus.out_ready  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk_eq("rst_op", 32'(bus.op), 32'd0);
        chk_eq("rst_din1", bus.din1_alu, 32'd0);
        chk_eq("rst_din2", bus.din2_alu, 32'd0);

        // Basic register read, one-cycle latency
        wb_write(5'd5, 32'h0000_000A);
        wb_write(5'd6, 32'h0000_0003);
        bus.out_ready = 1'b1;
        issue(5'd5, 5'd6, 4'b0110, 1'b0, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        chk_eq("basic_valid", 32'(bus.out_valid), 32'd1);
        chk_eq("basic_din1", bus.din1_alu, 32'h0000_000A);
        chk_eq("basic_din2", bus.din2_alu, 32'h0000_0003);
        chk_eq("basic_op", 32'(bus.op), 32'b0110);
        tick();
        chk_eq("basic_drain", 32'(bus.out_valid), 32'd0);

        // Register 0 stays zero; immediate select
        wb_write(5'd0, 32'hFFFF_FFFF);
        issue(5'd0, 5'd0, 4'h1, 1'b1, 32'h0000_0010);
        tick();
        bus.in_valid = 1'b0;
        chk_eq("r0_din1", bus.din1_alu, 32'd0);
        chk_eq("imm_din2", bus.din2_alu, 32'h0000_0010);
        issue(5'd0, 5'd0, 4'h2, 1'b0, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        chk_eq("r0_din2", bus.din2_alu, 32'd0);
        tick();

        // Stall: operands hold while write-back changes the source register
        bus.out_ready = 1'b0;
        issue(5'd5, 5'd6, 4'h3, 1'b0, 32'd0);
        tick();
        issue(5'd6, 5'd5, 4'h4, 1'b0, 32'd0);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'h1234_5678;
        chk_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.wb_en = 1'b0;
        chk_eq("stall_din1", bus.din1_alu, 32'h0000_000A);
        chk_eq("stall_valid", 32'(bus.out_valid), 32'd1);
        tick();
        chk_eq("stall_din1_2", bus.din1_alu, 32'h0000_000A);
        chk_eq("stall_op", 32'(bus.op), 32'h3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk_eq("stall_drain", 32'(bus.out_valid), 32'd0);
        issue(5'd5, 5'd0, 4'h5, 1'b0, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        chk_eq("stall_wb_seen", bus.din1_alu, 32'h1234_5678);
        tick();

        // Same-cycle write and read of one register
        wb_write(5'd7, 32'h0000_0001);
        issue(5'd7, 5'd0, 4'h6, 1'b0, 32'd0);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'h0000_0099;
        tick();
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        bypass_exp = 32'h0000_0099;
`else
        bypass_exp = 32'h0000_0001;
`endif
        chk_eq("bypass_din1", bus.din1_alu, bypass_exp);
        tick();

        // Back-to-back issues at full throughput
        for (int i = 0; i < 8; i++) wb_write(5'(i + 8), $urandom);
        for (int k = 0; k < 4; k++) begin
            issue(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), $urandom);
            chk_eq("b2b_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            chk_eq("b2b_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;
        tick();

        // Random traffic checked by the scoreboard
        for (int c = 0; c < 200; c++) begin
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_rs      = 5'($urandom);
            bus.in_rt      = 5'($urandom);
            bus.in_op      = 4'($urandom);
            bus.in_use_imm = 1'($urandom_range(0, 1));
            bus.in_imm     = $urandom;
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            bus.wb_en      = 1'($urandom_range(0, 1));
            bus.wb_addr    = 5'($urandom);
            bus.wb_data    = $urandom;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.wb_en     = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // Reset overrides pending output, write-back and acceptance
        wb_write(5'd3, 32'hDEAD_BEEF);
        bus.out_ready = 1'b0;
        issue(5'd3, 5'd3, 4'h7, 1'b0, 32'd0);
        tick();
        chk_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        bus.wb_en     = 1'b1;
        bus.wb_addr   = 5'd3;
        bus.wb_data   = 32'h0000_0055;
        issue(5'd3, 5'd3, 4'h8, 1'b0, 32'd0);
        tick();
        reset        = 1'b0;
        bus.wb_en    = 1'b0;
        bus.in_valid = 1'b0;
        chk_eq("rst2_valid", 32'(bus.out_valid), 32'd0);
        chk_eq("rst2_op", 32'(bus.op), 32'd0);
        chk_eq("rst2_din1", bus.din1_alu, 32'd0);
        chk_eq("rst2_din2", bus.din2_alu, 32'd0);
        chk_eq("rst2_in_ready", 32'(bus.in_ready), 32'd1);
        issue(5'd3, 5'd3, 4'h9, 1'b0, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        chk_eq("rst2_r3_din1", bus.din1_alu, 32'd0);
        chk_eq("rst2_r3_din2", bus.din2_alu, 32'd0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
